// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: debounce FSM state encoding.
package button_pkg;

  // Per-channel debounce states. The MSB doubles as the accepted level
  // (ST_HI and PEND_LO both report pressed).
  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One button channel: input polarity fix, synchroniser chain, counter-based
// debounce FSM, registered level and single-cycle press/release pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW_IN   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic                   p;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  btn_state_t             state;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;

  // Normalise so that 1 always means pressed before entering the chain.
  assign p = push ^ ACTIVE_LOW_IN;
  assign s = sync[SYNC_STAGES-1];

  // Plain flop chain; only sync[0] can see a metastable input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], p};
  end

  // A change is accepted on the sample that completes DEBOUNCE_CYCLES
  // consecutive samples opposite to the current level.
  always_comb begin
    accept = 1'b0;
    unique case (state)
      ST_LO:   accept = s && SINGLE;
      PEND_HI: accept = s && (cnt == CNT_LAST);
      ST_HI:   accept = !s && SINGLE;
      PEND_LO: accept = !s && (cnt == CNT_LAST);
      default: accept = 1'b0;
    endcase
  end

  // Only the low-side states can accept a press, so this is next-cycle rise.
  assign rise_next = accept && !state[1];

  // Debounce FSM with registered level and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        ST_LO: begin
          if (s) begin
            if (accept) begin
              state <= ST_HI;
              level <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= PEND_HI;
              cnt   <= CNT_ONE;
            end
          end
        end
        PEND_HI: begin
          if (!s) begin
            state <= ST_LO;
            cnt   <= '0;
          end else if (accept) begin
            state <= ST_HI;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HI: begin
          if (!s) begin
            if (accept) begin
              state <= ST_LO;
              level <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= PEND_LO;
              cnt   <= CNT_ONE;
            end
          end
        end
        PEND_LO: begin
          if (s) begin
            state <= ST_HI;
            cnt   <= '0;
          end else if (accept) begin
            state <= ST_LO;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LO;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: one independent debounce channel per
// button plus a registered any-press strobe aligned with the rise pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW_IN   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] push,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);

  logic [CHANNELS-1:0] rise_next;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW_IN  (ACTIVE_LOW_IN)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .level    (level[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .rise_next(rise_next[g])
    );
  end

  // Registered from the channels' next-rise terms so it lands with rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_rise <= 1'b0;
    else      any_rise <= |rise_next;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized hold
// times, every cycle compared against a run-length debounce model.
module tb_button_conditioner;

  localparam int CH = 2;
  localparam int SS = 2;
  localparam int DC = 16;
  localparam int HN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CH-1:0] push_a, push_b;
  logic [CH-1:0] level_a, rise_a, fall_a, level_b, rise_b, fall_b;
  logic          any_a, any_b;

  button_conditioner #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
                       .ACTIVE_LOW_IN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .push(push_a), .level(level_a), .rise(rise_a),
    .fall(fall_a), .any_rise(any_a));

  button_conditioner #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
                       .ACTIVE_LOW_IN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .push(push_b), .level(level_b), .rise(rise_b),
    .fall(fall_b), .any_rise(any_b));

  int checks = 0;
  int errors = 0;

  // Model: a press/release is accepted once DC consecutive synchronised
  // samples disagree with the current level; samples reach the debouncer
  // SS edges after they were taken at the pins.
  bit m_level [2][CH];
  int m_run   [2][CH];
  bit m_rise  [2][CH];
  bit m_fall  [2][CH];
  bit hist    [2][CH][HN];
  int m_e;

  task automatic model_reset();
    m_e = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        m_level[d][c] = 0; m_run[d][c] = 0; m_rise[d][c] = 0; m_fall[d][c] = 0;
        for (int k = 0; k < HN; k++) hist[d][c][k] = 0;
      end
  endtask

  task automatic model_edge();
    bit p, seen;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        p = (d == 0) ? push_a[c] : !push_b[c];
        seen = (m_e >= SS) ? hist[d][c][(m_e - SS) % HN] : 1'b0;
        hist[d][c][m_e % HN] = p;
        m_rise[d][c] = 0;
        m_fall[d][c] = 0;
        if (seen != m_level[d][c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == DC) begin
            m_level[d][c] = seen;
            if (seen) m_rise[d][c] = 1; else m_fall[d][c] = 1;
            m_run[d][c] = 0;
          end
        end else begin
          m_run[d][c] = 0;
        end
      end
    m_e++;
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] el, er, ef;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        el[c] = m_level[d][c]; er[c] = m_rise[d][c]; ef[c] = m_fall[d][c];
      end
      if (d == 0) begin
        chk("a.level", level_a, el); chk("a.rise", rise_a, er);
        chk("a.fall", fall_a, ef);   chk("a.any_rise", CH'(any_a), CH'(|er));
      end else begin
        chk("b.level", level_b, el); chk("b.rise", rise_b, er);
        chk("b.fall", fall_b, ef);   chk("b.any_rise", CH'(any_b), CH'(|er));
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] pa, input logic [CH-1:0] pb);
    push_a = pa;
    push_b = pb;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  // Assert reset with the given inputs, hold a few edges, release.
  task automatic do_reset(input logic [CH-1:0] pa, input logic [CH-1:0] pb);
    push_a = pa;
    push_b = pb;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b1;
  endtask

  initial begin
    int n_r, n_f, at_r, at_f, n_any;
    int hold_a [CH];
    int hold_b [CH];
    logic [CH-1:0] ra, rb;

    // Reset with random pins, then quiet release.
    push_a = '0; push_b = '1;
    rst = 1'b0;
    #1;
    model_reset();
    repeat (4) begin
      push_a = CH'($urandom); push_b = CH'($urandom);
      @(posedge clk);
      #1;
      check_all();
      chk("reset.level", level_a | level_b, '0);
      chk("reset.pulses", rise_a | fall_a | rise_b | fall_b | CH'(any_a) | CH'(any_b), '0);
    end
    push_a = '0; push_b = '1;
    rst = 1'b1;
    repeat (50) step(2'b00, 2'b11);
    chk("quiet.level", level_a, '0);

    // Clean press on channel 0.
    n_r = 0; at_r = 0;
    for (int i = 1; i <= 25; i++) begin
      step(2'b01, 2'b11);
      if (rise_a[0]) begin n_r++; if (at_r == 0) at_r = i; end
      chk("press.ch1_idle", CH'(level_a[1] | rise_a[1]), '0);
    end
    chk_int("press.rise_edge", at_r, 18);
    chk_int("press.rise_count", n_r, 1);
    repeat (30) step(2'b00, 2'b11);

    // Glitch of DC-1 samples on channel 1 is rejected.
    n_r = 0;
    for (int i = 0; i < 45; i++) begin
      step((i < 15) ? 2'b10 : 2'b00, 2'b11);
      if (rise_a[1]) n_r++;
    end
    chk_int("glitch15.rise_count", n_r, 0);
    chk("glitch15.level", level_a, '0);

    // Exactly DC samples is accepted, then released.
    n_r = 0; n_f = 0;
    for (int i = 0; i < 56; i++) begin
      step((i < 16) ? 2'b10 : 2'b00, 2'b11);
      if (rise_a[1]) n_r++;
      if (fall_a[1]) n_f++;
    end
    chk_int("glitch16.rise_count", n_r, 1);
    chk_int("glitch16.fall_count", n_f, 1);

    // Bouncy press: toggles every 3 cycles, then held.
    n_r = 0; at_r = 0;
    for (int i = 0; i < 30; i++) begin
      step(((i / 3) % 2 == 0) ? 2'b01 : 2'b00, 2'b11);
      if (rise_a[0]) n_r++;
    end
    for (int i = 1; i <= 30; i++) begin
      step(2'b01, 2'b11);
      if (rise_a[0]) begin n_r++; if (at_r == 0) at_r = i; end
    end
    chk_int("bounce.rise_count", n_r, 1);
    chk_int("bounce.rise_edge", at_r, 18);

    // Bouncy release with the mirrored pattern.
    n_f = 0; at_f = 0;
    for (int i = 0; i < 30; i++) begin
      step(((i / 3) % 2 == 0) ? 2'b00 : 2'b01, 2'b11);
      if (fall_a[0]) n_f++;
    end
    for (int i = 1; i <= 30; i++) begin
      step(2'b00, 2'b11);
      if (fall_a[0]) begin n_f++; if (at_f == 0) at_f = i; end
    end
    chk_int("bounce.fall_count", n_f, 1);
    chk_int("bounce.fall_edge", at_f, 18);

    // Simultaneous press on both channels.
    n_r = 0; n_any = 0; at_r = 0;
    for (int i = 1; i <= 25; i++) begin
      step(2'b11, 2'b11);
      if (rise_a != 2'b00) n_r++;
      if (any_a) n_any++;
      if (rise_a == 2'b11 && any_a) at_r = i;
    end
    chk_int("simul.both_edge", at_r, 18);
    chk_int("simul.rise_cycles", n_r, 1);
    chk_int("simul.any_count", n_any, 1);
    repeat (25) step(2'b00, 2'b11);

    // Active-low instance held pressed through reset release.
    do_reset(2'b00, 2'b00);
    at_r = 0;
    for (int i = 1; i <= 22; i++) begin
      step(2'b00, 2'b00);
      if (rise_b == 2'b11 && at_r == 0) at_r = i;
    end
    chk_int("al.rise_edge", at_r, 18);
    chk("al.level", level_b, 2'b11);

    // Start a release, then reset mid-debounce: level drops, no fall.
    repeat (5) step(2'b00, 2'b11);
    rst = 1'b0;
    #1;
    model_reset();
    chk("midreset.level", level_b, '0);
    chk("midreset.fall", fall_b, '0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    repeat (30) step(2'b00, 2'b11);

    // Random hold times around the debounce threshold.
    do_reset(2'b00, 2'b11);
    ra = '0; rb = '1;
    for (int c = 0; c < CH; c++) begin hold_a[c] = 1; hold_b[c] = 1; end
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (--hold_a[c] == 0) begin
          ra[c] = ~ra[c]; hold_a[c] = int'($urandom_range(1, 40));
        end
        if (--hold_b[c] == 0) begin
          rb[c] = ~rb[c]; hold_b[c] = int'($urandom_range(1, 40));
        end
      end
      step(ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
